commit_arbiter: RTL and testbench

Parametrised write-back arbiter for the core's commit stage. It replaces the single-source ALU-to-regfile path with NUM_FU functional-unit channels (ALU, memory, multiplier, ...). Each channel has a one-entry holding buffer and a valid/ready handshake. One buffered result per cycle is granted, by fixed priority or round-robin, and is presented as the registered regfile write port (rd6/wb_data6/we6). The block also keeps a retired-instruction counter.

---
 rtl/commit_arbiter.sv | 154 +++++++++++++++
 tb/tb_commit_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/commit_arbiter.sv
// Commit-stage write-back arbiter: NUM_FU one-entry result buffers, one grant per
// cycle (fixed priority or round-robin), registered regfile write port and retire counter.
module commit_arbiter #(
    parameter int NUM_FU   = 2,
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int ARB_MODE = 0,
    parameter int CNT_W    = 32,
    localparam int GID_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     flush,
    input  logic [NUM_FU-1:0]        fu_valid,
    output logic [NUM_FU-1:0]        fu_ready,
    input  logic [NUM_FU-1:0]        fu_we,
    input  logic [NUM_FU*REG_AW-1:0] fu_rd,
    input  logic [NUM_FU*XLEN-1:0]   fu_result,
    output logic                     wb_valid6,
    output logic                     we6,
    output logic [REG_AW-1:0]        rd6,
    output logic [XLEN-1:0]          wb_data6,
    output logic [GID_W-1:0]         grant_id6,
    output logic [CNT_W-1:0]         commit_cnt
);

    logic [NUM_FU-1:0] occ_q, occ_d;
    logic [NUM_FU-1:0] we_buf_q, we_buf_d;
    logic [REG_AW-1:0] rd_buf_q  [NUM_FU];
    logic [REG_AW-1:0] rd_buf_d  [NUM_FU];
    logic [XLEN-1:0]   res_buf_q [NUM_FU];
    logic [XLEN-1:0]   res_buf_d [NUM_FU];
    logic [GID_W-1:0]  last_q, last_d;

    logic              wb_valid_q, wb_valid_d;
    logic              we6_q, we6_d;
    logic [REG_AW-1:0] rd6_q, rd6_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic [GID_W-1:0]  grant_id_q, grant_id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NUM_FU-1:0] gnt;
    logic              gnt_any;
    logic [GID_W-1:0]  gnt_idx;
    logic [NUM_FU-1:0] accept;

    // Round-robin walks candidate offsets in order so the first occupied one after 'last' wins.
    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (!flush) begin
            if (ARB_MODE == 0) begin
                for (int i = 0; i < NUM_FU; i++) begin
                    if (!gnt_any && occ_q[i]) begin
                        gnt_any = 1'b1;
                        gnt_idx = GID_W'(i);
                        gnt[i]  = 1'b1;
                    end
                end
            end else begin
                for (int k = 0; k < NUM_FU; k++) begin
                    for (int i = 0; i < NUM_FU; i++) begin
                        if (!gnt_any && occ_q[i] &&
                            (i == ((int'(last_q) + 1 + k) % NUM_FU))) begin
                            gnt_any = 1'b1;
                            gnt_idx = GID_W'(i);
                            gnt[i]  = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign fu_ready = {NUM_FU{!nrst && !flush}} & (~occ_q | gnt);
    assign accept   = fu_valid & fu_ready;

    always_comb begin
        occ_d      = occ_q;
        we_buf_d   = we_buf_q;
        rd_buf_d   = rd_buf_q;
        res_buf_d  = res_buf_q;
        last_d     = last_q;
        wb_valid_d = gnt_any;
        we6_d      = 1'b0;
        rd6_d      = rd6_q;
        wb_data_d  = wb_data_q;
        grant_id_d = grant_id_q;
        cnt_d      = cnt_q;

        for (int i = 0; i < NUM_FU; i++) begin
            if (gnt[i]) begin
                occ_d[i]   = 1'b0;
                we6_d      = we_buf_q[i] && (rd_buf_q[i] != '0);
                rd6_d      = rd_buf_q[i];
                wb_data_d  = res_buf_q[i];
            end
            // Accept after grant so a same-cycle reload keeps the buffer occupied.
            if (accept[i]) begin
                occ_d[i]     = 1'b1;
                we_buf_d[i]  = fu_we[i];
                rd_buf_d[i]  = fu_rd[i*REG_AW +: REG_AW];
                res_buf_d[i] = fu_result[i*XLEN +: XLEN];
            end
        end

        if (gnt_any) begin
            grant_id_d = gnt_idx;
            last_d     = gnt_idx;
            cnt_d      = cnt_q + CNT_W'(1);
        end

        if (flush) begin
            occ_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            occ_q      <= '0;
            we_buf_q   <= '0;
            rd_buf_q   <= '{default: '0};
            res_buf_q  <= '{default: '0};
            last_q     <= GID_W'(NUM_FU - 1);
            wb_valid_q <= 1'b0;
            we6_q      <= 1'b0;
            rd6_q      <= '0;
            wb_data_q  <= '0;
            grant_id_q <= '0;
            cnt_q      <= '0;
        end else begin
            occ_q      <= occ_d;
            we_buf_q   <= we_buf_d;
            rd_buf_q   <= rd_buf_d;
            res_buf_q  <= res_buf_d;
            last_q     <= last_d;
            wb_valid_q <= wb_valid_d;
            we6_q      <= we6_d;
            rd6_q      <= rd6_d;
            wb_data_q  <= wb_data_d;
            grant_id_q <= grant_id_d;
            cnt_q      <= cnt_d;
        end
    end

    assign wb_valid6  = wb_valid_q;
    assign we6        = we6_q;
    assign rd6        = rd6_q;
    assign wb_data6   = wb_data_q;
    assign grant_id6  = grant_id_q;
    assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_commit_arbiter.sv
// Directed bench for commit_arbiter: a 2-channel fixed-priority instance with a 4-bit
// retire counter and a 4-channel round-robin instance, both sharing clock/reset/flush.
module tb_commit_arbiter;

    logic clk = 1'b0;
    logic nrst;
    logic flush;

    logic [1:0]   fu_valid_a, fu_ready_a, fu_we_a;
    logic [9:0]   fu_rd_a;
    logic [63:0]  fu_result_a;
    logic         wb_valid_a, we6_a;
    logic [4:0]   rd6_a;
    logic [31:0]  wb_data_a;
    logic [0:0]   grant_a;
    logic [3:0]   cnt_a;

    logic [3:0]   fu_valid_b, fu_ready_b, fu_we_b;
    logic [19:0]  fu_rd_b;
    logic [127:0] fu_result_b;
    logic         wb_valid_b, we6_b;
    logic [4:0]   rd6_b;
    logic [31:0]  wb_data_b;
    logic [1:0]   grant_b;
    logic [31:0]  cnt_b;

    int checks   = 0;
    int failures = 0;
    int rr_count [4];

    commit_arbiter #(.NUM_FU(2), .XLEN(32), .REG_AW(5), .ARB_MODE(0), .CNT_W(4)) dut_a (
        .clk(clk), .nrst(nrst), .flush(flush),
        .fu_valid(fu_valid_a), .fu_ready(fu_ready_a), .fu_we(fu_we_a),
        .fu_rd(fu_rd_a), .fu_result(fu_result_a),
        .wb_valid6(wb_valid_a), .we6(we6_a), .rd6(rd6_a), .wb_data6(wb_data_a),
        .grant_id6(grant_a), .commit_cnt(cnt_a)
    );

    commit_arbiter #(.NUM_FU(4), .XLEN(32), .REG_AW(5), .ARB_MODE(1), .CNT_W(32)) dut_b (
        .clk(clk), .nrst(nrst), .flush(flush),
        .fu_valid(fu_valid_b), .fu_ready(fu_ready_b), .fu_we(fu_we_b),
        .fu_rd(fu_rd_b), .fu_result(fu_result_b),
        .wb_valid6(wb_valid_b), .we6(we6_b), .rd6(rd6_b), .wb_data6(wb_data_b),
        .grant_id6(grant_b), .commit_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] we,
                                 input logic [4:0] rd0, input logic [31:0] res0,
                                 input logic [4:0] rd1, input logic [31:0] res1);
        fu_valid_a  = valid;
        fu_we_a     = we;
        fu_rd_a     = {rd1, rd0};
        fu_result_a = {res1, res0};
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        nrst        = 1'b1;
        flush       = 1'b0;
        fu_valid_b  = 4'b1111;
        fu_we_b     = 4'b1111;
        fu_rd_b     = '0;
        fu_result_b = '0;
        applyStimulus(2'b11, 2'b11, 5'd1, 32'h1, 5'd2, 32'h2);
        checkOutput("reset_ready_a", fu_ready_a, 2'b00);
        checkOutput("reset_ready_b", fu_ready_b, 4'b0000);

        for (int c = 0; c < 3; c++) begin
            stepClock();
            checkOutput("reset_ready_a_hold", fu_ready_a, 2'b00);
            checkOutput("reset_wb_valid", wb_valid_a, 1'b0);
            checkOutput("reset_we6", we6_a, 1'b0);
            checkOutput("reset_rd_data_gid", {rd6_a, wb_data_a, grant_a}, 64'h0);
            checkOutput("reset_cnt", cnt_a, 4'd0);
        end

        nrst       = 1'b0;
        fu_valid_b = 4'b0000;
        applyStimulus(2'b01, 2'b01, 5'd3, 32'hA5A5_0001, 5'd0, 32'h0);
        checkOutput("release_ready", fu_ready_a, 2'b11);
        stepClock();
        applyStimulus(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        checkOutput("first_wb_not_yet", wb_valid_a, 1'b0);
        checkOutput("first_cnt_zero", cnt_a, 4'd0);
        stepClock();
        checkOutput("first_wb_valid", wb_valid_a, 1'b1);
        checkOutput("first_we6", we6_a, 1'b1);
        checkOutput("first_rd6", rd6_a, 5'd3);
        checkOutput("first_data", wb_data_a, 32'hA5A5_0001);
        checkOutput("first_gid", grant_a, 1'b0);
        checkOutput("first_cnt", cnt_a, 4'd1);

        applyStimulus(2'b11, 2'b11, 5'd1, 32'h11, 5'd2, 32'h22);
        stepClock();
        applyStimulus(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        checkOutput("fp_no_commit_yet", wb_valid_a, 1'b0);
        checkOutput("fp_ready1_blocked", fu_ready_a, 2'b01);
        stepClock();
        checkOutput("fp_c0_valid", wb_valid_a, 1'b1);
        checkOutput("fp_c0_rd_data", {rd6_a, wb_data_a}, {5'd1, 32'h11});
        checkOutput("fp_c0_gid", grant_a, 1'b0);
        checkOutput("fp_ready1_back", fu_ready_a, 2'b11);
        stepClock();
        checkOutput("fp_c1_valid", wb_valid_a, 1'b1);
        checkOutput("fp_c1_rd_data", {rd6_a, wb_data_a}, {5'd2, 32'h22});
        checkOutput("fp_c1_gid", grant_a, 1'b1);
        checkOutput("fp_cnt", cnt_a, 4'd3);
        stepClock();
        checkOutput("idle_wb_valid", wb_valid_a, 1'b0);
        checkOutput("idle_we6", we6_a, 1'b0);
        checkOutput("idle_hold", {rd6_a, wb_data_a, grant_a}, {5'd2, 32'h22, 1'b1});

        for (int k = 1; k <= 10; k++) begin
            if (k <= 8) begin
                applyStimulus(2'b10, 2'b10, 5'd0, 32'h0, 5'd5, 32'(k));
                checkOutput("stream_ready", fu_ready_a[1], 1'b1);
            end else begin
                applyStimulus(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
            end
            stepClock();
            if (k >= 2 && k <= 9) begin
                checkOutput("stream_valid", wb_valid_a, 1'b1);
                checkOutput("stream_data", wb_data_a, 32'(k - 1));
            end
        end
        checkOutput("stream_end_valid", wb_valid_a, 1'b0);
        checkOutput("stream_cnt", cnt_a, 4'd11);

        applyStimulus(2'b01, 2'b01, 5'd0, 32'h55, 5'd0, 32'h0);
        stepClock();
        applyStimulus(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        stepClock();
        checkOutput("x0_valid", wb_valid_a, 1'b1);
        checkOutput("x0_we6", we6_a, 1'b0);
        checkOutput("x0_rd_data", {rd6_a, wb_data_a}, {5'd0, 32'h55});
        checkOutput("x0_cnt", cnt_a, 4'd12);

        applyStimulus(2'b11, 2'b11, 5'd7, 32'h77, 5'd8, 32'h88);
        stepClock();
        applyStimulus(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        stepClock();
        checkOutput("pre_flush_commit", {wb_valid_a, rd6_a}, {1'b1, 5'd7});
        checkOutput("pre_flush_cnt", cnt_a, 4'd13);
        flush = 1'b1;
        #1;
        checkOutput("flush_ready", fu_ready_a, 2'b00);
        stepClock();
        flush = 1'b0;
        #1;
        checkOutput("flush_wb_valid", wb_valid_a, 1'b0);
        checkOutput("flush_we6", we6_a, 1'b0);
        checkOutput("flush_occ_clear", fu_ready_a, 2'b11);
        for (int c = 0; c < 2; c++) begin
            stepClock();
            checkOutput("post_flush_valid", wb_valid_a, 1'b0);
            checkOutput("post_flush_cnt", cnt_a, 4'd13);
        end

        applyStimulus(2'b01, 2'b01, 5'd9, 32'h99, 5'd0, 32'h0);
        stepClock();
        nrst = 1'b1;
        #1;
        checkOutput("midreset_ready", fu_ready_a, 2'b00);
        stepClock();
        checkOutput("midreset_valid", wb_valid_a, 1'b0);
        checkOutput("midreset_cnt", cnt_a, 4'd0);
        checkOutput("midreset_rd6", rd6_a, 5'd0);
        nrst = 1'b0;
        applyStimulus(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        stepClock();
        checkOutput("midreset_discard", wb_valid_a, 1'b0);

        for (int k = 1; k <= 18; k++) begin
            if (k <= 17) applyStimulus(2'b01, 2'b01, 5'd4, 32'(k), 5'd0, 32'h0);
            else         applyStimulus(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
            stepClock();
            if (k == 17) checkOutput("wrap_cnt_16", cnt_a, 4'd0);
        end
        checkOutput("wrap_cnt_17", cnt_a, 4'd1);
        checkOutput("wrap_last_data", wb_data_a, 32'd17);

        fu_rd_b     = {5'd4, 5'd3, 5'd2, 5'd1};
        fu_result_b = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        for (int k = 1; k <= 17; k++) begin
            fu_valid_b = (k <= 16) ? 4'b1111 : 4'b0000;
            stepClock();
            if (k == 1) checkOutput("rr_ready_onehot", fu_ready_b, 4'b0001);
            if (k >= 2) begin
                checkOutput("rr_valid", wb_valid_b, 1'b1);
                checkOutput("rr_gid", grant_b, 64'((k - 2) % 4));
                checkOutput("rr_data", wb_data_b, 64'(32'hB0 + (k - 2) % 4));
                rr_count[grant_b]++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            checkOutput("rr_per_channel", 64'(rr_count[i]), 64'd4);
        end
        checkOutput("rr_cnt", cnt_b, 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
